adas_sensor_scheduler: RTL and testbench
========================================

Name: adas_sensor_scheduler

Overview:
Sequences distance acquisition from the lidar and camera sensor front-ends over independent req/ack handshakes on a fixed-period tick.
Captures one sample per sensor per round and presents both distances together.
Emits the one-cycle timer_trick strobe that paces the ADAS top-level controller and its averaging filter.
Flags per-sensor timeouts and missed-tick overruns.

Parameters:
TICK_DIV, 1000, clock cycles between acquisition rounds (>=2)
TIMEOUT, 64, max cycles a request waits for ack (>=1)
DW, 8, distance data width

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
enable_i  in  1  1 = run periodic rounds
lidar_req_o  out  1  request to lidar front-end
lidar_ack_i  in  1  lidar data valid / ack
lidar_data_i  in  DW  lidar distance
cam_req_o  out  1  request to camera front-end
cam_ack_i  in  1  camera data valid / ack
cam_data_i  in  DW  camera distance
distance_lidar_o  out  DW  last published lidar distance
distance_cam_o  out  DW  last published camera distance
timer_trick_o  out  1  one-cycle pulse: new distance pair published
sensor_fault_o  out  2  bit1 lidar timeout, bit0 camera timeout, for the last published round
overrun_o  out  1  one-cycle pulse: tick dropped because a round was in progress
busy_o  out  1  high while state != WAIT

Behaviour:
- Reset (async assert, sync-released internally by clk edge):
  - state=WAIT; tick_cnt=0; wait_cnt=0
  - All outputs 0. A req in flight drops immediately.
- Tick counter:
  - While enable_i=1, counts 0..TICK_DIV-1 and wraps to 0.
  - While enable_i=0, held at 0.
  - The wrap edge is a "tick".
- States:
  - WAIT:
    - On a tick, go to LIDAR and clear wait_cnt.
    - lidar_req_o=1 from the following cycle (registered).
  - LIDAR:
    - lidar_req_o=1.
    - On an edge with lidar_ack_i=1: capture lidar_data_i into the shadow register, clear lidar fault, go to CAM.
    - Else, if wait_cnt==TIMEOUT-1: keep the previous lidar shadow, set lidar fault, go to CAM.
    - Else, increment wait_cnt.
    - lidar_req_o is therefore high for at most TIMEOUT cycles.
  - CAM:
    - Same rules with cam_req_o, cam_ack_i, cam_data_i and the camera fault bit.
    - On exit, go to PUB.
  - PUB (exactly 1 cycle):
    - distance_lidar_o, distance_cam_o and sensor_fault_o are loaded from shadows on the edge entering PUB.
    - timer_trick_o=1 during PUB only.
    - Next state: WAIT.
- Requests:
  - Never both high.
  - Each drops the cycle after its ack or timeout.
- Ack/timeout collision: ack and timeout in the same cycle -> ack wins; data captured, no fault.
- Stray acks: an ack outside its request window is ignored.
- Minimum round: 3 cycles after the tick (ack on first req cycle for both).
- Maximum round: 2*TIMEOUT+1 cycles.
- Overrun:
  - A tick while state != WAIT is dropped.
  - overrun_o pulses 1 cycle; no round is queued.
- enable_i deassert mid-round:
  - The round completes and publishes normally.
  - No further ticks.
- Output hold: published outputs keep their value between rounds and across enable toggles (only reset clears them).
- Widths: wait_cnt is clog2(TIMEOUT) bits; tick_cnt is clog2(TICK_DIV) bits; no arithmetic on data.

Test Plan:
1. Bench params TICK_DIV=8, TIMEOUT=4. enable_i=1; both sensors ack on the 2nd req cycle with lidar=40, cam=44.
   -> distance_lidar_o=40, distance_cam_o=44, sensor_fault_o=00, one timer_trick_o pulse per 8 cycles, req pulses 2 cycles each.
2. After scenario 1, lidar never acks, cam acks with 50.
   -> lidar_req_o high exactly 4 cycles, distance_lidar_o stays 40, distance_cam_o=50, sensor_fault_o=10.
3. Lidar ack arrives on the 4th req cycle (timeout cycle) with data 33.
   -> distance_lidar_o=33, fault bit1=0.
4. TICK_DIV=8, TIMEOUT=4; both sensors time out (round = 9 cycles).
   -> overrun_o pulses once, that tick is skipped, next trick arrives on the following tick, fault=11, distances unchanged.
5. enable_i dropped during LIDAR state.
   -> round finishes, exactly one timer_trick_o pulse, then none; tick_cnt=0; busy_o=0.
6. rst_n asserted while cam_req_o=1.
   -> cam_req_o=0 immediately (no clock edge), all outputs 0. After release, first trick comes TICK_DIV cycles + round length later.

Source files
------------

// File: rtl/adas_sensor_scheduler.sv
// Periodic lidar/camera acquisition scheduler: one req/ack round per tick,
// publishes both distances with a one-cycle timer_trick strobe.
module adas_sensor_scheduler #(
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned DW       = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable_i,
  output logic          lidar_req_o,
  input  logic          lidar_ack_i,
  input  logic [DW-1:0] lidar_data_i,
  output logic          cam_req_o,
  input  logic          cam_ack_i,
  input  logic [DW-1:0] cam_data_i,
  output logic [DW-1:0] distance_lidar_o,
  output logic [DW-1:0] distance_cam_o,
  output logic          timer_trick_o,
  output logic [1:0]    sensor_fault_o,
  output logic          overrun_o,
  output logic          busy_o
);

  localparam int unsigned TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_WAIT,
    S_LIDAR,
    S_CAM,
    S_PUB
  } state_e;

  state_e         state_q;
  logic [TCW-1:0] tick_cnt_q, tick_cnt_d;
  logic [WCW-1:0] wait_cnt_q;
  logic [DW-1:0]  shadow_lidar_q, shadow_cam_q;
  logic           fault_lidar_q, fault_cam_q;
  logic           lidar_req_q, cam_req_q, trick_q, overrun_q, busy_q;
  logic [DW-1:0]  dist_lidar_q, dist_cam_q;
  logic [1:0]     fault_q;
  logic           tick;

  assign tick = enable_i && (tick_cnt_q == TICK_LAST);

  always_comb begin
    tick_cnt_d = '0;
    if (enable_i && (tick_cnt_q != TICK_LAST)) begin
      tick_cnt_d = tick_cnt_q + TCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_WAIT;
      wait_cnt_q     <= '0;
      shadow_lidar_q <= '0;
      shadow_cam_q   <= '0;
      fault_lidar_q  <= 1'b0;
      fault_cam_q    <= 1'b0;
      lidar_req_q    <= 1'b0;
      cam_req_q      <= 1'b0;
      trick_q        <= 1'b0;
      overrun_q      <= 1'b0;
      busy_q         <= 1'b0;
      dist_lidar_q   <= '0;
      dist_cam_q     <= '0;
      fault_q        <= '0;
    end else begin
      trick_q   <= 1'b0;
      overrun_q <= tick && (state_q != S_WAIT);
      unique case (state_q)
        S_WAIT: begin
          if (tick) begin
            state_q     <= S_LIDAR;
            wait_cnt_q  <= '0;
            lidar_req_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        S_LIDAR: begin
          if (lidar_ack_i || (wait_cnt_q == WAIT_LAST)) begin
            state_q     <= S_CAM;
            wait_cnt_q  <= '0;
            lidar_req_q <= 1'b0;
            cam_req_q   <= 1'b1;
            if (lidar_ack_i) begin
              shadow_lidar_q <= lidar_data_i;
              fault_lidar_q  <= 1'b0;
            end else begin
              fault_lidar_q  <= 1'b1;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + WCW'(1);
          end
        end
        S_CAM: begin
          // The camera result lands in the shadow and the published outputs on
          // the same edge, so the outputs take the freshly resolved value.
          if (cam_ack_i || (wait_cnt_q == WAIT_LAST)) begin
            state_q      <= S_PUB;
            wait_cnt_q   <= '0;
            cam_req_q    <= 1'b0;
            trick_q      <= 1'b1;
            dist_lidar_q <= shadow_lidar_q;
            if (cam_ack_i) begin
              shadow_cam_q <= cam_data_i;
              fault_cam_q  <= 1'b0;
              dist_cam_q   <= cam_data_i;
              fault_q      <= {fault_lidar_q, 1'b0};
            end else begin
              fault_cam_q  <= 1'b1;
              dist_cam_q   <= shadow_cam_q;
              fault_q      <= {fault_lidar_q, 1'b1};
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + WCW'(1);
          end
        end
        S_PUB: begin
          state_q <= S_WAIT;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_WAIT;
      endcase
    end
  end

  assign lidar_req_o      = lidar_req_q;
  assign cam_req_o        = cam_req_q;
  assign distance_lidar_o = dist_lidar_q;
  assign distance_cam_o   = dist_cam_q;
  assign timer_trick_o    = trick_q;
  assign sensor_fault_o   = fault_q;
  assign overrun_o        = overrun_q;
  assign busy_o           = busy_q;

endmodule

// File: tb/tb_adas_sensor_scheduler.sv
// Randomized bench for adas_sensor_scheduler: sensor responders plan each round,
// a monitor checks timing against a tick/round model and pops published results.
`timescale 1ns/1ps
module tb_adas_sensor_scheduler;

  localparam int unsigned TICK_DIV = 8;
  localparam int unsigned TIMEOUT  = 4;
  localparam int unsigned DW       = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable_i = 1'b0;
  logic          lidar_ack_i = 1'b0;
  logic          cam_ack_i = 1'b0;
  logic [DW-1:0] lidar_data_i = '0;
  logic [DW-1:0] cam_data_i = '0;
  logic          lidar_req_o, cam_req_o, timer_trick_o, overrun_o, busy_o;
  logic [DW-1:0] distance_lidar_o, distance_cam_o;
  logic [1:0]    sensor_fault_o;

  adas_sensor_scheduler #(
    .TICK_DIV(TICK_DIV),
    .TIMEOUT (TIMEOUT),
    .DW      (DW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable_i        (enable_i),
    .lidar_req_o     (lidar_req_o),
    .lidar_ack_i     (lidar_ack_i),
    .lidar_data_i    (lidar_data_i),
    .cam_req_o       (cam_req_o),
    .cam_ack_i       (cam_ack_i),
    .cam_data_i      (cam_data_i),
    .distance_lidar_o(distance_lidar_o),
    .distance_cam_o  (distance_cam_o),
    .timer_trick_o   (timer_trick_o),
    .sensor_fault_o  (sensor_fault_o),
    .overrun_o       (overrun_o),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] dl;
    logic [DW-1:0] dc;
    logic [1:0]    flt;
  } exp_t;

  exp_t exp_q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Plan for the next round (k = req cycle on which the sensor acks; k > TIMEOUT = never).
  int unsigned   nxt_kl, nxt_kc, cur_kl, cur_kc;
  logic [DW-1:0] nxt_dl, nxt_dc, cur_dl, cur_dc;
  logic [DW-1:0] m_dl, m_dc;
  logic          m_fl, m_fc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned pick_k();
    case ($urandom_range(0, 3))
      0:       return 1;
      1:       return $urandom_range(1, TIMEOUT);
      2:       return TIMEOUT;
      default: return TIMEOUT + 1;
    endcase
  endfunction

  function automatic int req_cycles(input int unsigned k);
    return (k < TIMEOUT) ? int'(k) : int'(TIMEOUT);
  endfunction

  task automatic new_plan();
    nxt_kl = pick_k();
    nxt_kc = pick_k();
    nxt_dl = DW'($urandom);
    nxt_dc = DW'($urandom);
  endtask

  // Sensor responders: ack on the planned req cycle, stray acks when idle.
  initial begin : driver
    int unsigned lcnt, ccnt;
    lcnt = 0;
    ccnt = 0;
    m_dl = '0; m_dc = '0; m_fl = 1'b0; m_fc = 1'b0;
    new_plan();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        lcnt = 0; ccnt = 0;
        lidar_ack_i = 1'b0; cam_ack_i = 1'b0;
        m_dl = '0; m_dc = '0; m_fl = 1'b0; m_fc = 1'b0;
        continue;
      end
      if (lidar_req_o) begin
        lcnt++;
        if (lcnt == 1) begin
          exp_t e;
          cur_kl = nxt_kl; cur_kc = nxt_kc; cur_dl = nxt_dl; cur_dc = nxt_dc;
          if (cur_kl <= TIMEOUT) begin m_dl = cur_dl; m_fl = 1'b0; end else m_fl = 1'b1;
          if (cur_kc <= TIMEOUT) begin m_dc = cur_dc; m_fc = 1'b0; end else m_fc = 1'b1;
          e.dl = m_dl; e.dc = m_dc; e.flt = {m_fl, m_fc};
          exp_q.push_back(e);
          new_plan();
        end
        lidar_ack_i  = (lcnt == cur_kl);
        lidar_data_i = lidar_ack_i ? cur_dl : DW'($urandom);
      end else begin
        lcnt = 0;
        lidar_ack_i  = ($urandom_range(0, 3) == 0);
        lidar_data_i = DW'($urandom);
      end
      if (cam_req_o) begin
        ccnt++;
        cam_ack_i  = (ccnt == cur_kc);
        cam_data_i = cam_ack_i ? cur_dc : DW'($urandom);
      end else begin
        ccnt = 0;
        cam_ack_i  = ($urandom_range(0, 3) == 0);
        cam_data_i = DW'($urandom);
      end
    end
  end

  // Monitor: ticks every TICK_DIV enabled edges; a round occupies
  // nL lidar cycles, nC camera cycles and one publish cycle.
  initial begin : monitor
    int cyc, run, rs, nl, nc, e, ci;
    logic tick, active, exp_ovr;
    logic [DW-1:0] pub_dl, pub_dc;
    logic [1:0] pub_f;
    exp_t x;
    cyc = 0; run = 0; rs = 0; nl = 0; nc = 0; active = 1'b0;
    pub_dl = '0; pub_dc = '0; pub_f = '0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        cyc = 0; run = 0; active = 1'b0;
        pub_dl = '0; pub_dc = '0; pub_f = '0;
        continue;
      end
      cyc++;
      run = enable_i ? run + 1 : 0;
      tick = enable_i && ((run % TICK_DIV) == 0);
      exp_ovr = 1'b0;
      if (tick) begin
        if (active && (cyc - 1 <= rs + nl + nc)) exp_ovr = 1'b1;
        else begin
          active = 1'b1; rs = cyc;
          nl = req_cycles(nxt_kl); nc = req_cycles(nxt_kc);
        end
      end
      @(negedge clk);
      if (!rst_n) continue;
      ci = cyc;
      e  = rs + nl + nc;
      check("overrun", overrun_o, exp_ovr);
      check("busy", busy_o, active && ci >= rs && ci <= e);
      check("lidar_req", lidar_req_o, active && ci >= rs && ci < rs + nl);
      check("cam_req", cam_req_o, active && ci >= rs + nl && ci < e);
      check("timer_trick", timer_trick_o, active && ci == e);
      if (timer_trick_o) begin
        if (exp_q.size() == 0) begin
          check("trick_without_round", 1, 0);
        end else begin
          x = exp_q.pop_front();
          pub_dl = x.dl; pub_dc = x.dc; pub_f = x.flt;
        end
      end
      check("distance_lidar", distance_lidar_o, pub_dl);
      check("distance_cam", distance_cam_o, pub_dc);
      check("sensor_fault", sensor_fault_o, pub_f);
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_lidar_req"}, lidar_req_o, 0);
    check({tag, "_cam_req"}, cam_req_o, 0);
    check({tag, "_dist_lidar"}, distance_lidar_o, 0);
    check({tag, "_dist_cam"}, distance_cam_o, 0);
    check({tag, "_trick"}, timer_trick_o, 0);
    check({tag, "_fault"}, sensor_fault_o, 0);
    check({tag, "_overrun"}, overrun_o, 0);
    check({tag, "_busy"}, busy_o, 0);
  endtask

  task automatic random_run(input int unsigned cycles);
    for (int unsigned i = 0; i < cycles; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 149) == 0) enable_i = ~enable_i;
    end
  endtask

  initial begin : main
    int unsigned w;
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    enable_i = 1'b1;
    random_run(1500);

    // Drop enable while the lidar request is outstanding.
    enable_i = 1'b1;
    w = 0;
    while (!lidar_req_o && w < 200) begin @(negedge clk); w++; end
    check("wait_lidar_req", lidar_req_o, 1);
    enable_i = 1'b0;
    repeat (30) @(negedge clk);
    check("idle_busy", busy_o, 0);
    check("idle_queue_empty", exp_q.size(), 0);
    enable_i = 1'b1;

    // Asynchronous reset while the camera request is outstanding.
    w = 0;
    while (!cam_req_o && w < 200) begin @(negedge clk); w++; end
    check("wait_cam_req", cam_req_o, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    random_run(1500);

    enable_i = 1'b0;
    repeat (2 * TIMEOUT + TICK_DIV + 4) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
